// File: rtl/watch_mode_ctrl_if.sv
// Button inputs and display/status outputs of the watch controller.
// The master side drives the buttons and the slave side is the controller.
interface watch_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_start;
    logic       btn_change;
    logic [3:0] s_unidade;
    logic [3:0] s_dezena;
    logic [3:0] m_unidade;
    logic [3:0] m_dezena;
    logic [3:0] h_unidade;
    logic [3:0] h_dezena;
    logic [1:0] mode;
    logic       sw_running;
    logic       lap_hold;
    logic       set_field;

    modport master (
        output btn_mode, btn_start, btn_change,
        input  s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena,
        input  mode, sw_running, lap_hold, set_field
    );

    modport slave (
        input  btn_mode, btn_start, btn_change,
        output s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena,
        output mode, sw_running, lap_hold, set_field
    );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Three-mode watch controller: time-of-day clock, stopwatch with lap hold and time-set.
// Keeps its own second prescaler and BCD counters and muxes six BCD digits to the display.
module watch_mode_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter bit          HOUR_24     = 1'b1,
    parameter int unsigned SW_HOUR_MAX = 99
) (
    input  logic               clk,
    input  logic               reset,
    watch_mode_ctrl_if.slave   io
);
    localparam int unsigned PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]  CLK_HMAX  = HOUR_24 ? 8'h23 : 8'h12;
    localparam logic [7:0]  CLK_HMIN  = HOUR_24 ? 8'h00 : 8'h01;
    localparam logic [7:0]  CLK_HRST  = HOUR_24 ? 8'h00 : 8'h12;
    localparam logic [7:0]  SW_HMAX   = {4'(SW_HOUR_MAX / 10), 4'(SW_HOUR_MAX % 10)};

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SW    = 2'b01,
        MODE_SET   = 2'b10
    } mode_e;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
    } bcd_time_t;

    // Two-digit BCD increment that wraps from vmax back to vmin.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] vmax,
                                            input logic [7:0] vmin);
        logic [7:0] r;
        if (v == vmax)            r = vmin;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // One-second advance with the s -> m -> h carry chain.
    function automatic bcd_time_t time_step(input bcd_time_t t, input logic [7:0] hmax,
                                            input logic [7:0] hmin);
        bcd_time_t r;
        r   = t;
        r.s = bcd_step(t.s, 8'h59, 8'h00);
        if (t.s == 8'h59) begin
            r.m = bcd_step(t.m, 8'h59, 8'h00);
            if (t.m == 8'h59) r.h = bcd_step(t.h, hmax, hmin);
        end
        return r;
    endfunction

    mode_e      mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_time_t  clk_q, clk_d;
    bcd_time_t  sw_q, sw_d;
    bcd_time_t  lap_q, lap_d;
    logic       run_q, run_d;
    logic       lap_hold_q, lap_hold_d;
    logic       set_field_q, set_field_d;
    logic [2:0] prev_q, prev_d;
    logic       tick, mode_press, start_press, change_press;
    bcd_time_t  disp;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= MODE_CLOCK;
            presc_q     <= '0;
            clk_q       <= {CLK_HRST, 8'h00, 8'h00};
            sw_q        <= '0;
            lap_q       <= '0;
            run_q       <= 1'b0;
            lap_hold_q  <= 1'b0;
            set_field_q <= 1'b0;
            prev_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            clk_q       <= clk_d;
            sw_q        <= sw_d;
            lap_q       <= lap_d;
            run_q       <= run_d;
            lap_hold_q  <= lap_hold_d;
            set_field_q <= set_field_d;
            prev_q      <= prev_d;
        end
    end

    always_comb begin
        mode_d       = mode_q;
        clk_d        = clk_q;
        sw_d         = sw_q;
        lap_d        = lap_q;
        run_d        = run_q;
        lap_hold_d   = lap_hold_q;
        set_field_d  = set_field_q;
        prev_d       = {io.btn_mode, io.btn_start, io.btn_change};
        mode_press   = io.btn_mode   & ~prev_q[2];
        start_press  = io.btn_start  & ~prev_q[1];
        change_press = io.btn_change & ~prev_q[0];
        tick         = (presc_q == PRESC_MAX);
        presc_d      = tick ? '0 : presc_q + PW'(1);

        if (tick && mode_q != MODE_SET) clk_d = time_step(clk_q, CLK_HMAX, CLK_HMIN);
        if (tick && run_q)              sw_d  = time_step(sw_q, SW_HMAX, 8'h00);

        // A mode press masks any start/change press in the same cycle.
        if (mode_press) begin
            case (mode_q)
                MODE_CLOCK: mode_d = MODE_SW;
                MODE_SW: begin
                    mode_d      = MODE_SET;
                    lap_hold_d  = 1'b0;
                    set_field_d = 1'b0;
                end
                default: begin
                    mode_d    = MODE_CLOCK;
                    clk_d.s   = 8'h00;
                    presc_d   = '0;
                end
            endcase
        end else begin
            case (mode_q)
                MODE_SW: begin
                    if (start_press) run_d = ~run_q;
                    // Change action decides on the pre-toggle run state; clear beats a tick.
                    if (change_press) begin
                        if (lap_hold_q) begin
                            lap_hold_d = 1'b0;
                        end else if (run_q) begin
                            lap_d      = sw_q;
                            lap_hold_d = 1'b1;
                        end else begin
                            sw_d = '0;
                        end
                    end
                end
                MODE_SET: begin
                    if (change_press) set_field_d = ~set_field_q;
                    if (start_press) begin
                        if (!set_field_q) clk_d.h = bcd_step(clk_q.h, CLK_HMAX, CLK_HMIN);
                        else              clk_d.m = bcd_step(clk_q.m, 8'h59, 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        disp = clk_q;
        if (mode_q == MODE_SW) disp = lap_hold_q ? lap_q : sw_q;
    end

    assign io.h_dezena   = disp.h[7:4];
    assign io.h_unidade  = disp.h[3:0];
    assign io.m_dezena   = disp.m[7:4];
    assign io.m_unidade  = disp.m[3:0];
    assign io.s_dezena   = disp.s[7:4];
    assign io.s_unidade  = disp.s[3:0];
    assign io.mode       = mode_q;
    assign io.sw_running = run_q;
    assign io.lap_hold   = lap_hold_q;
    assign io.set_field  = set_field_q;
endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Multi-mode digital watch controller with three modes: time-of-day clock, stopwatch with lap capture, and time-set. Owns its own second prescaler and BCD time/stopwatch counters. Selects which six BCD digits drive the display decoder. Successor to the two-mode watch FSM: adds a parametrised tick rate, lap hold, a clock time-set mode, and a 12/24-hour option.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
HOUR_24, 1, 1 = clock wraps 23:59:59->00:00:00; 0 = 12h, wraps 12:59:59->01:00:00
SW_HOUR_MAX, 99, stopwatch hour limit (BCD-representable, <=99); wraps to 00:00:00 past SW_HOUR_MAX:59:59

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_mode  in  1  level, already synchronised; rising edge cycles mode
btn_start  in  1  level; rising edge = start/pause (stopwatch) or increment field (set)
btn_change  in  1  level; rising edge = clear/lap (stopwatch) or select field (set)
s_unidade  out  4  displayed seconds units, BCD
s_dezena  out  4  displayed seconds tens
m_unidade  out  4  displayed minutes units
m_dezena  out  4  displayed minutes tens
h_unidade  out  4  displayed hours units
h_dezena  out  4  displayed hours tens
mode  out  2  00 CLOCK, 01 STOPWATCH, 10 SET_TIME
sw_running  out  1  stopwatch counting
lap_hold  out  1  display frozen on lap value
set_field  out  1  0 = hours selected, 1 = minutes selected (SET_TIME only)

Behaviour:
- Reset (reset=0 at posedge): mode=CLOCK; clock=00:00:00 (HOUR_24=1) or 12:00:00 (HOUR_24=0); stopwatch=00:00:00; prescaler=0; sw_running=0; lap_hold=0; set_field=0; button edge registers=0.
- Edge detect: a press is btn_x=1 while its prev register=0. Each press acts exactly once; holding a button has no further effect.
- Prescaler counts 0..TICK_DIV-1. tick=1 for one cycle when count=TICK_DIV-1, then the counter returns to 0. The prescaler runs in all modes.
- Clock counter: advances on tick in CLOCK and STOPWATCH modes. It is frozen in SET_TIME. Carry chain: s 59->0 carries into m; m 59->0 carries into h; hours wrap per HOUR_24.
- Stopwatch counter: advances on tick only when sw_running=1, regardless of current mode. It wraps to 00:00:00 after SW_HOUR_MAX:59:59.
- Mode transitions on btn_mode press:
  - CLOCK -> STOPWATCH.
  - STOPWATCH -> SET_TIME.
  - SET_TIME -> CLOCK. On leaving SET_TIME, clock seconds are cleared to 00 and the prescaler resets to 0.
  - Entering SET_TIME sets set_field=0.
- STOPWATCH mode:
  - btn_start press toggles sw_running.
  - btn_change press while sw_running=1 and lap_hold=0: latch the current stopwatch value into the lap register and set lap_hold=1.
  - btn_change press while lap_hold=1: lap_hold=0.
  - btn_change press while sw_running=0 and lap_hold=0: stopwatch cleared to 00:00:00.
  - btn_start while lap_hold=1 toggles run only; lap_hold is unchanged.
- SET_TIME mode:
  - btn_change press toggles set_field.
  - btn_start press increments the selected field by 1 with wrap and no carry. Hours: 23->00 (24h) or 12->01 (12h). Minutes: 59->00.
- Display mux (combinational from registers):
  - CLOCK and SET_TIME show the clock value.
  - STOPWATCH shows the lap register if lap_hold=1, else the live stopwatch.
- Leaving STOPWATCH forces lap_hold=0. The stopwatch keeps running in the background if sw_running=1.
- Priority within one cycle: a btn_mode press wins; btn_start and btn_change presses in that same cycle are ignored. btn_start and btn_change together in STOPWATCH: the start toggle and the change action both apply, with the change action evaluated against the pre-toggle sw_running.
- A tick coinciding with a stopwatch clear: the clear wins, result is 00:00:00. A tick coinciding with a lap latch: the latched value is the pre-increment value.
- Digits are always valid BCD (0-9; tens 0-5 for min/sec).
- Reset asserted mid-operation returns every state and output to reset values on that edge.

Test Plan:
- TICK_DIV=4, reset, hold 240 cycles -> clock display 00:01:00; mode=00.
- Preload via SET_TIME to 23:59 (h field 23 presses, min field 59 presses), exit, 60 ticks -> 00:00:00, sw counter untouched; repeat with HOUR_24=0 from 12:59 -> 01:00:00.
- btn_mode once, btn_start, 5 ticks, btn_change -> lap_hold=1, display frozen at 00:00:05 while 3 more ticks pass; btn_change -> display 00:00:08.
- In STOPWATCH: pause at 00:00:08, btn_change -> 00:00:00. Start again, switch to CLOCK, 10 ticks, return -> stopwatch 00:00:10, sw_running=1.
- btn_mode and btn_start same cycle in STOPWATCH -> mode=SET_TIME, sw_running unchanged. Held btn_start for 20 cycles in SET_TIME -> exactly one increment.
- Stopwatch with SW_HOUR_MAX=1 preset near 01:59:59 (run 7199 ticks), one more tick -> 00:00:00. Reset low mid-run -> all outputs at reset values next edge.
